// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
// Requests follow a valid/ready handshake; load data returns later on a response strobe.
interface mem_wb_stage_if;
   logic        memReqValid;
   logic        memReqReady;
   logic        memReqWe;
   logic [31:0] memReqAddr;
   logic [31:0] memReqWdata;
   logic [3:0]  memReqBe;
   logic        memRespValid;
   logic [31:0] memRespRdata;

   modport master (
      output memReqValid,
      output memReqWe,
      output memReqAddr,
      output memReqWdata,
      output memReqBe,
      input  memReqReady,
      input  memRespValid,
      input  memRespRdata
   );

   modport slave (
      input  memReqValid,
      input  memReqWe,
      input  memReqAddr,
      input  memReqWdata,
      input  memReqBe,
      output memReqReady,
      output memRespValid,
      output memRespRdata
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register of the RV32I pipeline: issues loads/stores over a
// variable-latency data bus, stalls upstream while busy, and registers the write-back triple.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no access outstanding; non-memory results pass to WB in one cycle
// REQ    | request presented on the bus, waiting for memReqReady
// WAIT   | load accepted, waiting for memRespValid
module mem_wb_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  RegWrite_i,
   input  logic [1:0]            WriteSrc_i,
   input  logic                  MemRead_i,
   input  logic                  MemWrite_i,
   input  logic [4:0]            rd_i,
   input  logic [2:0]            funct3_i,
   input  logic [31:0]           ALUResult_i,
   input  logic [31:0]           storeData_i,
   input  logic [31:0]           pcPlus4_i,
   input  logic [31:0]           ImmOp_i,
   mem_wb_stage_if.master        dmem,
   output logic                  stall_o,
   output logic                  memErr_o,
   output logic                  RegWriteWB_o,
   output logic [4:0]            writeRegAddr_o,
   output logic [31:0]           WD3_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;

   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_q;
   logic        regwrite_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        err_q;

   logic        mem_op;
   logic        f3_legal;
   logic        misaligned;
   logic        acc_err;
   logic        start;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic        req_hs;
   logic        store_done;
   logic        load_done;
   logic        timeout_hit;
   logic        abort;
   logic [31:0] wb_sel;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;

   // Access legality, evaluated on the instruction presented in IDLE
   assign mem_op = MemRead_i | MemWrite_i;

   always_comb begin
      f3_legal = 1'b0;
      if (MemRead_i && MemWrite_i) begin
         f3_legal = 1'b0;
      end else if (MemRead_i) begin
         case (funct3_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
         endcase
      end else if (MemWrite_i) begin
         case (funct3_i)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            default:                f3_legal = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (funct3_i[1:0])
         2'b01:   misaligned = ALUResult_i[0];
         2'b10:   misaligned = (ALUResult_i[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   assign acc_err = mem_op && (!f3_legal || misaligned);
   assign start   = (state_q == S_IDLE) && mem_op && !acc_err;

   // Byte enables follow access size; store data is replicated across all lanes
   always_comb begin
      case (funct3_i[1:0])
         2'b00: begin
            be_d    = 4'b0001 << ALUResult_i[1:0];
            wdata_d = {4{storeData_i[7:0]}};
         end
         2'b01: begin
            be_d    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{storeData_i[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = storeData_i;
         end
      endcase
      if (!MemWrite_i) begin
         wdata_d = '0;
      end
   end

   assign req_hs      = (state_q == S_REQ) && dmem.memReqReady;
   assign store_done  = req_hs && we_q;
   assign load_done   = (state_q == S_WAIT) && dmem.memRespValid;
   assign timeout_hit = TO_EN && (cnt_q == TO_LAST) &&
                        ((state_q == S_REQ) || (state_q == S_WAIT));
   // A completion landing on the final budget cycle still counts as success
   assign abort       = timeout_hit && !store_done && !load_done;

   always_comb begin
      case (state_q)
         S_IDLE:  stall_o = start;
         S_REQ:   stall_o = !store_done && !abort;
         S_WAIT:  stall_o = !load_done && !abort;
         default: stall_o = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_REQ;
         end
         S_REQ: begin
            if (abort)       state_d = S_IDLE;
            else if (req_hs) state_d = we_q ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (abort || load_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE) cnt_q <= '0;
         else                   cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q     <= '0;
         funct3_q   <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
      end else if (start) begin
         addr_q     <= ALUResult_i;
         funct3_q   <= funct3_i;
         rd_q       <= rd_i;
         regwrite_q <= RegWrite_i;
         we_q       <= MemWrite_i;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
      end
   end

   assign dmem.memReqValid = (state_q == S_REQ);
   assign dmem.memReqWe    = we_q;
   assign dmem.memReqAddr  = {addr_q[31:2], 2'b00};
   assign dmem.memReqBe    = be_q;
   assign dmem.memReqWdata = wdata_q;

   // Load extraction from the returned word using the latched lane
   assign byte_sel = dmem.memRespRdata[{addr_q[1:0], 3'b000} +: 8];
   assign half_sel = addr_q[1] ? dmem.memRespRdata[31:16] : dmem.memRespRdata[15:0];

   always_comb begin
      case (funct3_q)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = dmem.memRespRdata;
      endcase
   end

   always_comb begin
      case (WriteSrc_i)
         2'b00:   wb_sel = ALUResult_i;
         2'b10:   wb_sel = pcPlus4_i;
         2'b11:   wb_sel = ImmOp_i;
         default: wb_sel = '0;
      endcase
   end

   // Every cycle that is not a completion or a plain ALU pass-through loads a bubble
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         RegWriteWB_o   <= 1'b0;
         writeRegAddr_o <= '0;
         WD3_o          <= '0;
         err_q          <= 1'b0;
      end else begin
         err_q <= ((state_q == S_IDLE) && acc_err) || abort;
         if (load_done) begin
            RegWriteWB_o   <= regwrite_q;
            writeRegAddr_o <= rd_q;
            WD3_o          <= load_val;
         end else if ((state_q == S_IDLE) && !mem_op) begin
            RegWriteWB_o   <= RegWrite_i;
            writeRegAddr_o <= rd_i;
            WD3_o          <= wb_sel;
         end else begin
            RegWriteWB_o   <= 1'b0;
            writeRegAddr_o <= '0;
            WD3_o          <= '0;
         end
      end
   end

   assign memErr_o = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized instructions
// compared against a transaction-level reference model.
module tb_mem_wb_stage;
   localparam int T = 8;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        RegWrite_i;
   logic [1:0]  WriteSrc_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [4:0]  rd_i;
   logic [2:0]  funct3_i;
   logic [31:0] ALUResult_i;
   logic [31:0] storeData_i;
   logic [31:0] pcPlus4_i;
   logic [31:0] ImmOp_i;
   logic        stall_o;
   logic        memErr_o;
   logic        RegWriteWB_o;
   logic [4:0]  writeRegAddr_o;
   logic [31:0] WD3_o;

   mem_wb_stage_if dmem();

   mem_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .RegWrite_i     (RegWrite_i),
      .WriteSrc_i     (WriteSrc_i),
      .MemRead_i      (MemRead_i),
      .MemWrite_i     (MemWrite_i),
      .rd_i           (rd_i),
      .funct3_i       (funct3_i),
      .ALUResult_i    (ALUResult_i),
      .storeData_i    (storeData_i),
      .pcPlus4_i      (pcPlus4_i),
      .ImmOp_i        (ImmOp_i),
      .dmem           (dmem),
      .stall_o        (stall_o),
      .memErr_o       (memErr_o),
      .RegWriteWB_o   (RegWriteWB_o),
      .writeRegAddr_o (writeRegAddr_o),
      .WD3_o          (WD3_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic acc_error(input logic mr, input logic mw, input logic [2:0] f3,
                                      input logic [31:0] addr);
      int unsigned f;
      f = f3;
      if (mr && mw) return 1'b1;
      if (mr && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 1'b1;
      if (mw && f > 2) return 1'b1;
      if ((f % 4) == 1 && (addr % 2) != 0) return 1'b1;
      if ((f % 4) == 2 && (addr % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      int unsigned lane;
      logic [31:0] b, h;
      lane = addr % 4;
      b = (rdata >> (8 * lane)) & 32'hFF;
      h = (rdata >> (8 * (lane & 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'h1_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned lane;
      lane = addr % 4;
      case (f3 % 4)
         0:       return 4'(1 << lane);
         1:       return 4'(3 << lane);
         default: return 4'd15;
      endcase
   endfunction

   function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] sd);
      case (f3 % 4)
         0:       return (sd & 32'hFF) * 32'h0101_0101;
         1:       return (sd & 32'hFFFF) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   task automatic drive(input logic rw, input logic [1:0] ws, input logic mr, input logic mw,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [31:0] pc4, input logic [31:0] imm);
      RegWrite_i  = rw;
      WriteSrc_i  = ws;
      MemRead_i   = mr;
      MemWrite_i  = mw;
      rd_i        = rd;
      funct3_i    = f3;
      ALUResult_i = alu;
      storeData_i = sd;
      pcPlus4_i   = pc4;
      ImmOp_i     = imm;
   endtask

   // Presents one instruction until the stage releases it, plays the memory side, then
   // samples write-back in the following (NOP) cycle and compares against the model.
   task automatic run_instr(input logic rw, input logic [1:0] ws, input logic mr, input logic mw,
                            input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] alu,
                            input logic [31:0] sd, input logic [31:0] pc4, input logic [31:0] imm,
                            input int rdy, input int rsp, input logic [31:0] rdata);
      logic is_mem, bad, tmo, hs, done;
      int span, exp_st, exp_vc, exp_ec, exp_wc;
      int st, vc, ec, wc, cyc, req_seen, hs_age;
      logic [31:0] exp_wd, wd_obs;
      logic [4:0]  wa_obs;

      is_mem = mr | mw;
      bad    = is_mem && acc_error(mr, mw, f3, alu);
      span   = mw ? rdy + 1 : rdy + 1 + rsp;
      tmo    = is_mem && !bad && span > T;
      exp_st = 0; exp_vc = 0; exp_ec = 0; exp_wc = 0; exp_wd = 0;
      if (!is_mem) begin
         exp_wc = int'(rw);
         exp_wd = (ws == 2'd0) ? alu : (ws == 2'd2) ? pc4 : (ws == 2'd3) ? imm : 32'd0;
      end else if (bad) begin
         exp_ec = 1;
      end else if (tmo) begin
         exp_st = T;
         exp_vc = (rdy + 1 < T) ? rdy + 1 : T;
         exp_ec = 1;
      end else if (mw) begin
         exp_st = rdy + 1;
         exp_vc = rdy + 1;
      end else begin
         exp_st = rdy + rsp + 1;
         exp_vc = rdy + 1;
         exp_wc = int'(rw);
         exp_wd = load_value(f3, alu, rdata);
      end

      st = 0; vc = 0; ec = 0; wc = 0; cyc = 0; req_seen = 0; hs_age = 0;
      hs = 1'b0; done = 1'b0;
      while (!done && cyc < 64) begin
         @(posedge clk_i); #1;
         drive(rw, ws, mr, mw, rd, f3, alu, sd, pc4, imm);
         dmem.memReqReady  = 1'b0;
         dmem.memRespValid = 1'b0;
         dmem.memRespRdata = rdata;
         if (hs) begin
            hs_age++;
            if (hs_age == rsp) dmem.memRespValid = 1'b1;
         end else if (dmem.memReqValid) begin
            req_seen++;
            if (req_seen == rdy + 1) dmem.memReqReady = 1'b1;
         end
         @(negedge clk_i);
         if (dmem.memReqValid) begin
            vc++;
            check_val("req_addr", dmem.memReqAddr, alu & 32'hFFFF_FFFC);
            check_val("req_we_be", {dmem.memReqWe, dmem.memReqBe}, {mw, be_of(f3, alu)});
            if (mw) check_val("req_wdata", dmem.memReqWdata, wdata_of(f3, sd));
            if (dmem.memReqReady && !mw) hs = 1'b1;
         end
         if (stall_o) st++;
         else         done = 1'b1;
         ec += int'(memErr_o);
         wc += int'(RegWriteWB_o);
         cyc++;
      end
      check_val("release", done, 1'b1);

      @(posedge clk_i); #1;
      drive(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      dmem.memReqReady  = 1'b0;
      dmem.memRespValid = 1'b0;
      @(negedge clk_i);
      if (dmem.memReqValid) vc++;
      ec += int'(memErr_o);
      wc += int'(RegWriteWB_o);
      wa_obs = writeRegAddr_o;
      wd_obs = WD3_o;

      check_val("stall_cycles", st, exp_st);
      check_val("req_cycles", vc, exp_vc);
      check_val("err_pulses", ec, exp_ec);
      check_val("wb_pulses", wc, exp_wc);
      if (exp_wc == 1) begin
         check_val("wb_addr", wa_obs, rd);
         check_val("wb_data", wd_obs, exp_wd);
      end
   endtask

   initial begin
      logic        rw, mr, mw;
      logic [1:0]  ws;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu, sd, pc4, imm, rdata;
      logic        hs;
      int          kind, v;

      rst_i = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      dmem.memReqReady  = 1'b0;
      dmem.memRespValid = 1'b0;
      dmem.memRespRdata = 32'd0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_val("rst_valid", dmem.memReqValid, 1'b0);
      check_val("rst_stall", stall_o, 1'b0);
      check_val("rst_err", memErr_o, 1'b0);
      check_val("rst_wb", {RegWriteWB_o, writeRegAddr_o, WD3_o}, 38'd0);
      check_val("rst_req", {dmem.memReqAddr, dmem.memReqBe, dmem.memReqWe}, 37'd0);

      // ADD
      run_instr(1'b1, 2'b00, 1'b0, 1'b0, 5'd5, 3'd0, 32'h0000_1234, 32'd0, 32'h44, 32'h99, 0, 1, 32'd0);
      // LW with ready after 2 cycles, response 3 cycles later
      run_instr(1'b1, 2'b01, 1'b1, 1'b0, 5'd7, 3'b010, 32'h100, 32'd0, 32'd0, 32'd0, 2, 3, 32'hDEAD_BEEF);
      run_instr(1'b1, 2'b01, 1'b1, 1'b0, 5'd8, 3'b000, 32'h203, 32'd0, 32'd0, 32'd0, 0, 1, 32'h8000_0000);
      run_instr(1'b1, 2'b01, 1'b1, 1'b0, 5'd9, 3'b100, 32'h203, 32'd0, 32'd0, 32'd0, 1, 2, 32'h8000_0000);
      run_instr(1'b1, 2'b01, 1'b1, 1'b0, 5'd10, 3'b001, 32'h202, 32'd0, 32'd0, 32'd0, 0, 1, 32'h8001_0000);
      // SB to lane 2
      run_instr(1'b0, 2'b00, 1'b0, 1'b1, 5'd0, 3'b000, 32'h302, 32'h0000_00AB, 32'd0, 32'd0, 1, 1, 32'd0);
      // misaligned LW
      run_instr(1'b1, 2'b01, 1'b1, 1'b0, 5'd11, 3'b010, 32'h1002, 32'd0, 32'd0, 32'd0, 0, 1, 32'd0);
      // ready never comes: timeout
      run_instr(1'b1, 2'b01, 1'b1, 1'b0, 5'd12, 3'b010, 32'h400, 32'd0, 32'd0, 32'd0, 100, 1, 32'd0);
      // rd = 0 passes through
      run_instr(1'b1, 2'b11, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'hABCD_0000, 0, 1, 32'd0);

      // Reset during WAIT, then stray responses
      hs = 1'b0;
      for (int c = 0; c < 10 && !hs; c++) begin
         @(posedge clk_i); #1;
         drive(1'b1, 2'b01, 1'b1, 1'b0, 5'd13, 3'b010, 32'h500, 32'd0, 32'd0, 32'd0);
         dmem.memReqReady = dmem.memReqValid;
         @(negedge clk_i);
         if (dmem.memReqValid && dmem.memReqReady) hs = 1'b1;
      end
      check_val("rst_test_hs", hs, 1'b1);
      @(posedge clk_i); #1;
      dmem.memReqReady = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      @(negedge clk_i);
      check_val("midrst_valid", dmem.memReqValid, 1'b0);
      check_val("midrst_stall", stall_o, 1'b0);
      check_val("midrst_out", {memErr_o, RegWriteWB_o, writeRegAddr_o, WD3_o}, 39'd0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk_i); #1;
         dmem.memRespValid = (c < 3);
         dmem.memRespRdata = 32'h1357_9BDF;
         @(negedge clk_i);
         check_val("stray_resp_wb", RegWriteWB_o, 1'b0);
      end

      for (int i = 0; i < 150; i++) begin
         kind  = $urandom_range(0, 9);
         rw    = 1'($urandom_range(0, 1));
         rd    = 5'($urandom);
         f3    = 3'($urandom);
         alu   = $urandom;
         if ($urandom_range(0, 2) == 0) alu[1:0] = 2'b00;
         sd    = $urandom;
         pc4   = $urandom;
         imm   = $urandom;
         rdata = $urandom;
         mr = 1'b0; mw = 1'b0; ws = 2'b01;
         if (kind < 4) begin
            v  = $urandom_range(0, 2);
            ws = (v == 0) ? 2'b00 : (v == 1) ? 2'b10 : 2'b11;
         end else if (kind < 7) begin
            mr = 1'b1;
         end else if (kind < 9) begin
            mw = 1'b1;
            rw = 1'b0;
            f3 = 3'($urandom_range(0, 3));
         end else begin
            mr = 1'b1;
            mw = 1'b1;
         end
         run_instr(rw, ws, mr, mw, rd, f3, alu, sd, pc4, imm,
                   $urandom_range(0, 4), $urandom_range(1, 4), rdata);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
